// File: rtl/cae_pkg.sv
// Shared types and helpers for the odd-even merge network compare-and-exchange stages.
package cae_pkg;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  localparam int unsigned KEY_MAX = 64;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_e;

  // Keys arrive zero-extended to KEY_MAX; flipping the key MSB turns a
  // two's-complement order into a plain unsigned order.
  function automatic logic key_lt(
    input logic               is_signed,
    input int unsigned        width,
    input logic [KEY_MAX-1:0] a,
    input logic [KEY_MAX-1:0] b
  );
    logic [KEY_MAX-1:0] flip;
    flip = KEY_MAX'(is_signed) << (width - 1);
    return (a ^ flip) < (b ^ flip);
  endfunction

endpackage

// File: rtl/cae_skid.sv
// Two-entry valid/ready skid buffer, 1-cycle latency, full throughput.
// in_rdy is registered and depends only on occupancy; out_dat holds while stalled.
module cae_skid
  import cae_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_vld_q, out_vld_d;
  logic             in_rdy_q, in_rdy_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_vld && in_rdy_q;
  assign out_xfer = out_vld_q && out_rdy;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_dat;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_xfer && !out_xfer) begin
          skid_d  = in_dat;
          state_d = SKID_FULL;
        end else if (out_xfer && !in_xfer) begin
          state_d = SKID_EMPTY;
        end else if (in_xfer && out_xfer) begin
          main_d  = in_dat;
        end
      end
      SKID_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    out_vld_d = (state_d != SKID_EMPTY);
    in_rdy_d  = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SKID_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      out_vld_q <= out_vld_d;
      in_rdy_q  <= in_rdy_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = out_vld_q;
  assign out_dat = main_q;

endmodule

// File: rtl/cae_stream.sv
// Handshaked compare-and-exchange of one key/tag pair per transfer, 1-cycle latency.
// Stalls through a two-entry skid; x_ready is registered and never follows y_ready directly.
module cae_stream
  import cae_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned TAG_WIDTH = 8,
  parameter bit          SIGNED    = 1'b0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic                 x_desc,
  input  logic [KEY_WIDTH-1:0] x_key_0,
  input  logic [KEY_WIDTH-1:0] x_key_1,
  input  logic [TAG_WIDTH-1:0] x_tag_0,
  input  logic [TAG_WIDTH-1:0] x_tag_1,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [KEY_WIDTH-1:0] y_key_0,
  output logic [KEY_WIDTH-1:0] y_key_1,
  output logic [TAG_WIDTH-1:0] y_tag_0,
  output logic [TAG_WIDTH-1:0] y_tag_1,
  output logic                 y_swapped,
  output logic [CNT_WIDTH-1:0] swap_count
);

  localparam int unsigned PW = 1 + 2 * (KEY_WIDTH + TAG_WIDTH);

  logic [KEY_MAX-1:0]   k0_ext, k1_ext;
  logic                 swap;
  logic                 in_xfer;
  logic [PW-1:0]        in_dat, out_dat;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign k0_ext = KEY_MAX'(x_key_0);
  assign k1_ext = KEY_MAX'(x_key_1);

  // Strict compares in both directions, so equal keys keep their order.
  always_comb begin
    if (x_desc == DIR_DESC) swap = key_lt(SIGNED, KEY_WIDTH, k0_ext, k1_ext);
    else                    swap = key_lt(SIGNED, KEY_WIDTH, k1_ext, k0_ext);
  end

  assign in_dat = swap ? {1'b1, x_key_1, x_tag_1, x_key_0, x_tag_0}
                       : {1'b0, x_key_0, x_tag_0, x_key_1, x_tag_1};

  assign in_xfer = x_valid && x_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (in_xfer && swap && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  cae_skid #(.WIDTH(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (x_valid),
    .in_rdy  (x_ready),
    .in_dat  (in_dat),
    .out_vld (y_valid),
    .out_rdy (y_ready),
    .out_dat (out_dat)
  );

  assign {y_swapped, y_key_0, y_tag_0, y_key_1, y_tag_1} = out_dat;
  assign swap_count = cnt_q;

endmodule

// File: tb/tb_cae_stream.sv
// Directed bench: an unsigned (2-bit counter) and a signed instance share all stimulus.
module tb_cae_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x_valid, x_desc, y_ready;
  logic [7:0] x_key_0, x_key_1, x_tag_0, x_tag_1;

  logic        xr_u, yv_u, ysw_u, xr_s, yv_s, ysw_s;
  logic [7:0]  yk0_u, yk1_u, yt0_u, yt1_u, yk0_s, yk1_s, yt0_s, yt1_s;
  logic [1:0]  cnt_u;
  logic [15:0] cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cae_stream #(.KEY_WIDTH(8), .TAG_WIDTH(8), .SIGNED(1'b0), .CNT_WIDTH(2)) dut_u (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xr_u), .x_desc(x_desc),
    .x_key_0(x_key_0), .x_key_1(x_key_1), .x_tag_0(x_tag_0), .x_tag_1(x_tag_1),
    .y_valid(yv_u), .y_ready(y_ready), .y_key_0(yk0_u), .y_key_1(yk1_u),
    .y_tag_0(yt0_u), .y_tag_1(yt1_u), .y_swapped(ysw_u), .swap_count(cnt_u)
  );

  cae_stream #(.KEY_WIDTH(8), .TAG_WIDTH(8), .SIGNED(1'b1), .CNT_WIDTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xr_s), .x_desc(x_desc),
    .x_key_0(x_key_0), .x_key_1(x_key_1), .x_tag_0(x_tag_0), .x_tag_1(x_tag_1),
    .y_valid(yv_s), .y_ready(y_ready), .y_key_0(yk0_s), .y_key_1(yk1_s),
    .y_tag_0(yt0_s), .y_tag_1(yt1_s), .y_swapped(ysw_s), .swap_count(cnt_s)
  );

  // Output packed as {swapped, key_0, tag_0, key_1, tag_1}.
  logic [32:0] y_u, y_s;
  assign y_u = {ysw_u, yk0_u, yt0_u, yk1_u, yt1_u};
  assign y_s = {ysw_s, yk0_s, yt0_s, yk1_s, yt1_s};

  typedef struct {
    logic        desc;
    logic [7:0]  k0, k1, t0, t1;
    logic [32:0] e_u;
    logic [32:0] e_s;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mkv(input logic d, input logic [7:0] k0, input logic [7:0] k1,
                               input logic [7:0] t0, input logic [7:0] t1,
                               input logic [32:0] eu, input logic [32:0] es);
    vec_t v;
    v.desc = d; v.k0 = k0; v.k1 = k1; v.t0 = t0; v.t1 = t1; v.e_u = eu; v.e_s = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic [7:0] k0, input logic [7:0] k1,
                       input logic [7:0] t0, input logic [7:0] t1);
    x_valid = 1'b1; x_desc = d; x_key_0 = k0; x_key_1 = k1; x_tag_0 = t0; x_tag_1 = t1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " y_valid_u"}, 64'(yv_u), 64'd0);
    chk({tag, " y_valid_s"}, 64'(yv_s), 64'd0);
    chk({tag, " x_ready_u"}, 64'(xr_u), 64'd1);
    chk({tag, " x_ready_s"}, 64'(xr_s), 64'd1);
    chk({tag, " y_data_u"},  64'(y_u),  64'd0);
    chk({tag, " y_data_s"},  64'(y_s),  64'd0);
    chk({tag, " count_u"},   64'(cnt_u), 64'd0);
    chk({tag, " count_s"},   64'(cnt_s), 64'd0);
  endtask

  initial begin
    logic [1:0]  exp_cu;
    logic [15:0] exp_cs;
    logic        bp_rdy[10];
    logic        bp_xr[10];
    logic [32:0] pexp[4];
    logic [32:0] cap_u, cap_s;
    logic        in_go, out_go;
    int          tx, rx;

    vt[0] = mkv(1'b0, 8'h09, 8'h03, 8'h0A, 8'h0B, {1'b1, 8'h03, 8'h0B, 8'h09, 8'h0A}, {1'b1, 8'h03, 8'h0B, 8'h09, 8'h0A});
    vt[1] = mkv(1'b1, 8'h80, 8'h7F, 8'h01, 8'h02, {1'b0, 8'h80, 8'h01, 8'h7F, 8'h02}, {1'b1, 8'h7F, 8'h02, 8'h80, 8'h01});
    vt[2] = mkv(1'b1, 8'h05, 8'h05, 8'h01, 8'h02, {1'b0, 8'h05, 8'h01, 8'h05, 8'h02}, {1'b0, 8'h05, 8'h01, 8'h05, 8'h02});
    vt[3] = mkv(1'b0, 8'h80, 8'h7F, 8'h03, 8'h04, {1'b1, 8'h7F, 8'h04, 8'h80, 8'h03}, {1'b0, 8'h80, 8'h03, 8'h7F, 8'h04});
    vt[4] = mkv(1'b0, 8'h05, 8'h05, 8'h07, 8'h08, {1'b0, 8'h05, 8'h07, 8'h05, 8'h08}, {1'b0, 8'h05, 8'h07, 8'h05, 8'h08});
    vt[5] = mkv(1'b1, 8'h03, 8'h09, 8'h0C, 8'h0D, {1'b1, 8'h09, 8'h0D, 8'h03, 8'h0C}, {1'b1, 8'h09, 8'h0D, 8'h03, 8'h0C});
    vt[6] = mkv(1'b0, 8'hFF, 8'h00, 8'h0E, 8'h0F, {1'b1, 8'h00, 8'h0F, 8'hFF, 8'h0E}, {1'b0, 8'hFF, 8'h0E, 8'h00, 8'h0F});
    vt[7] = mkv(1'b0, 8'h01, 8'h02, 8'h10, 8'h11, {1'b0, 8'h01, 8'h10, 8'h02, 8'h11}, {1'b0, 8'h01, 8'h10, 8'h02, 8'h11});
    vt[8] = mkv(1'b1, 8'h00, 8'hFF, 8'h12, 8'h13, {1'b1, 8'hFF, 8'h13, 8'h00, 8'h12}, {1'b0, 8'h00, 8'h12, 8'hFF, 8'h13});

    rst_n = 1'b0; x_valid = 1'b0; x_desc = 1'b0; y_ready = 1'b1;
    x_key_0 = '0; x_key_1 = '0; x_tag_0 = '0; x_tag_1 = '0;
    step(); step();
    chk_reset("reset");
    rst_n = 1'b1;

    // Back-to-back vectors at full throughput; each result appears one edge later.
    exp_cu = '0; exp_cs = '0;
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].desc, vt[i].k0, vt[i].k1, vt[i].t0, vt[i].t1);
      if (vt[i].e_u[32]) exp_cu = (exp_cu == 2'd3) ? 2'd3 : exp_cu + 2'd1;
      if (vt[i].e_s[32]) exp_cs = exp_cs + 16'd1;
      step();
      chk($sformatf("vec%0d y_valid_u", i), 64'(yv_u), 64'd1);
      chk($sformatf("vec%0d y_u", i), 64'(y_u), 64'(vt[i].e_u));
      chk($sformatf("vec%0d y_s", i), 64'(y_s), 64'(vt[i].e_s));
      chk($sformatf("vec%0d count_u", i), 64'(cnt_u), 64'(exp_cu));
      chk($sformatf("vec%0d count_s", i), 64'(cnt_s), 64'(exp_cs));
    end
    chk("sat count_u final", 64'(cnt_u), 64'd3);
    x_valid = 1'b0;
    step();
    chk("drain y_valid_u", 64'(yv_u), 64'd0);
    chk("drain y_valid_s", 64'(yv_s), 64'd0);

    // Four pairs with y_ready low for three cycles mid-stream.
    bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bp_xr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 4; j++)
      pexp[j] = {1'b0, 8'(j + 1), 8'(8'h20 + j), 8'(8'h11 + j), 8'(8'h30 + j)};
    tx = 0; rx = 0;
    for (int c = 0; c < 10; c++) begin
      if (tx < 4) drive(1'b0, 8'(tx + 1), 8'(8'h11 + tx), 8'(8'h20 + tx), 8'(8'h30 + tx));
      else        x_valid = 1'b0;
      y_ready = bp_rdy[c];
      chk($sformatf("bp c%0d x_ready_u", c), 64'(xr_u), 64'(bp_xr[c]));
      chk($sformatf("bp c%0d x_ready_s", c), 64'(xr_s), 64'(bp_xr[c]));
      in_go  = x_valid && xr_u;
      out_go = yv_u && y_ready;
      cap_u  = y_u;
      cap_s  = y_s;
      step();
      if (in_go) tx++;
      if (out_go) begin
        if (rx < 4) begin
          chk($sformatf("bp out%0d y_u", rx), 64'(cap_u), 64'(pexp[rx]));
          chk($sformatf("bp out%0d y_s", rx), 64'(cap_s), 64'(pexp[rx]));
        end else begin
          chk("bp extra output", 64'(rx), 64'd3);
        end
        rx++;
      end
    end
    chk("bp accepted", 64'(tx), 64'd4);
    chk("bp delivered", 64'(rx), 64'd4);
    chk("bp idle y_valid", 64'(yv_u), 64'd0);

    // Fill to FULL, then reset mid-operation.
    y_ready = 1'b0;
    drive(1'b0, 8'h09, 8'h03, 8'h01, 8'h02);
    step();
    drive(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
    step();
    chk("full x_ready_u", 64'(xr_u), 64'd0);
    chk("full count_s", 64'(cnt_s), 64'd4);
    rst_n = 1'b0; x_valid = 1'b0;
    step();
    chk_reset("full-reset");
    rst_n = 1'b1; y_ready = 1'b1;
    drive(1'b0, 8'h20, 8'h10, 8'h05, 8'h06);
    step();
    chk("post-reset y_valid", 64'(yv_u), 64'd1);
    chk("post-reset y_u", 64'(y_u), 64'({1'b1, 8'h10, 8'h06, 8'h20, 8'h05}));
    chk("post-reset y_s", 64'(y_s), 64'({1'b1, 8'h10, 8'h06, 8'h20, 8'h05}));
    chk("post-reset count_u", 64'(cnt_u), 64'd1);
    chk("post-reset count_s", 64'(cnt_s), 64'd1);
    x_valid = 1'b0;
    step();
    chk("post-reset drain", 64'(yv_s), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
